pipe_stage_skid: RTL and testbench

//  Parametrised pipeline stage register with a valid/ready handshake, an optional 2-entry skid buffer,

---
 rtl/pipe_stage_skid.sv | 128 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// pipe_stage_skid : valid/ready pipeline register, optional 2-entry skid, flush
// Revision: 1.0
// ============================================================================
module pipe_stage_skid #(
  parameter int CTRL_W      = 11,
  parameter int DATA_W      = 111,
  parameter int SKID        = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             occupancy,
  input  logic                   clr_stats,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  // State encoding equals the number of held entries.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              accept;
  logic              take;
  logic              load_in;
  logic              from_skid;
  logic              bubble;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_ONE;
      ST_ONE: begin
        if (accept && !take && (SKID != 0)) state_nxt = ST_TWO;
        else if (!accept && take)           state_nxt = ST_EMPTY;
      end
      ST_TWO:   if (take) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
    if (flush) state_nxt = ST_EMPTY;
  end

  always_comb begin
    out_valid = (state != ST_EMPTY);
    occupancy = state;
    load_in   = accept && ((state == ST_EMPTY) || ((state == ST_ONE) && take));
    from_skid = (state == ST_TWO) && take;
    bubble    = (state_nxt == ST_EMPTY);
  end

  // Payload survives bubbles and flush; only the control field is zeroed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ctrl <= '0;
      out_data <= '0;
    end else begin
      if (bubble)         out_ctrl <= '0;
      else if (from_skid) out_ctrl <= skid_ctrl;
      else if (load_in)   out_ctrl <= in_ctrl;
      if (!flush) begin
        if (from_skid)    out_data <= skid_data;
        else if (load_in) out_data <= in_data;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic load_skid;
      logic ready_q;

      assign load_skid = (state == ST_ONE) && accept && !take && !flush;
      assign in_ready  = ready_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ready_q   <= 1'b0;
          skid_ctrl <= '0;
          skid_data <= '0;
        end else begin
          ready_q <= (state_nxt != ST_TWO);
          if (load_skid) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end
        end
      end
    end else begin : g_no_skid
      assign skid_ctrl = '0;
      assign skid_data = '0;
      assign in_ready  = rst_n & (!out_valid | out_ready);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_stats) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_skid : directed checks of pipe_stage_skid (SKID=1, narrow counter, SKID=0)
// Revision: 1.0
// ============================================================================
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, flush, out_ready, clr_stats;
  logic [10:0]  in_ctrl;
  logic [110:0] in_data;
  wire          in_ready, out_valid;
  wire  [10:0]  out_ctrl;
  wire  [110:0] out_data;
  wire  [1:0]   occupancy;
  wire  [15:0]  stall_cnt;

  wire          s_in_ready, s_out_valid;
  wire  [10:0]  s_out_ctrl;
  wire  [110:0] s_out_data;
  wire  [1:0]   s_occupancy;
  wire  [3:0]   s_stall_cnt;

  logic         n_valid, n_ready;
  logic [10:0]  n_ctrl;
  logic [110:0] n_data;
  wire          n_in_ready, n_out_valid;
  wire  [10:0]  n_out_ctrl;
  wire  [110:0] n_out_data;
  wire  [1:0]   n_occupancy;
  wire  [15:0]  n_stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .clr_stats(clr_stats), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.STALL_CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .occupancy(s_occupancy), .clr_stats(clr_stats), .stall_cnt(s_stall_cnt)
  );

  pipe_stage_skid #(.SKID(0)) u_nsk (
    .clk(clk), .rst_n(rst_n), .in_valid(n_valid), .in_ready(n_in_ready),
    .in_ctrl(n_ctrl), .in_data(n_data), .flush(1'b0), .out_valid(n_out_valid),
    .out_ready(n_ready), .out_ctrl(n_out_ctrl), .out_data(n_out_data),
    .occupancy(n_occupancy), .clr_stats(1'b0), .stall_cnt(n_stall_cnt)
  );

  function automatic logic [10:0] cf(input logic [110:0] d);
    return d[10:0] ^ 11'h7F0;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [110:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = cf(d);
  endtask

  task automatic ndrive(input logic v, input logic [110:0] d);
    n_valid = v;
    n_data  = d;
    n_ctrl  = cf(d);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    drive(1'b0, '0);
    n_ready = 1'b0;
    ndrive(1'b0, '0);
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    #1 check("rel_in_ready_low", in_ready, 0);
    tick();
    check("rel_in_ready_high", in_ready, 1);

    // Streaming 8 beats, one cycle latency, no gaps
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 111'(i));
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, 128'(i));
      check("stream_ctrl", out_ctrl, cf(111'(i)));
    end
    drive(1'b0, '0);
    tick();
    check("stream_drain_valid", out_valid, 0);
    check("stream_bubble_ctrl", out_ctrl, 0);
    check("stream_hold_data", out_data, 8);
    check("stream_stall", stall_cnt, 0);

    // Back-pressure: A then B with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 111'hA);
    tick();
    check("bp_occ1", occupancy, 1);
    check("bp_ready1", in_ready, 1);
    drive(1'b1, 111'hB);
    tick();
    check("bp_occ2", occupancy, 2);
    check("bp_ready0", in_ready, 0);
    drive(1'b1, 111'hC);
    tick(); tick();
    check("bp_stall3", stall_cnt, 3);
    check("bp_no_overflow_data", out_data, 111'hA);
    check("bp_occ2_hold", occupancy, 2);
    drive(1'b0, '0);
    out_ready = 1'b1;
    tick();
    check("bp_take_b_data", out_data, 111'hB);
    check("bp_take_b_ctrl", out_ctrl, cf(111'hB));
    check("bp_occ_after_take", occupancy, 1);
    check("bp_ready_back", in_ready, 1);
    tick();
    check("bp_empty", out_valid, 0);
    check("bp_stall_kept", stall_cnt, 3);

    // Flush with two held entries and a beat C offered
    out_ready = 1'b0;
    drive(1'b1, 111'h11);
    tick();
    drive(1'b1, 111'h12);
    tick();
    check("fl_occ2", occupancy, 2);
    drive(1'b1, 111'h13);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0);
    check("fl_valid", out_valid, 0);
    check("fl_ctrl", out_ctrl, 0);
    check("fl_occ", occupancy, 0);
    check("fl_ready", in_ready, 1);
    check("fl_data_kept", out_data, 111'h11);
    check("fl_stall_kept", stall_cnt, 5);
    out_ready = 1'b1;
    tick(); tick();
    check("fl_c_dropped", out_valid, 0);

    // Saturation on the 4-bit counter, clr_stats
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_main", stall_cnt, 0);
    check("clr_sat", s_stall_cnt, 0);
    out_ready = 1'b0;
    drive(1'b1, 111'h21);
    tick();
    drive(1'b0, '0);
    repeat (20) tick();
    check("sat_main20", stall_cnt, 20);
    check("sat_narrow15", s_stall_cnt, 15);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("clr_beats_inc_main", stall_cnt, 0);
    check("clr_beats_inc_sat", s_stall_cnt, 0);

    // Asynchronous reset mid-stream with two entries held
    drive(1'b1, 111'h22);
    tick();
    drive(1'b0, '0);
    check("mr_occ2", occupancy, 2);
    check("mr_stall1", stall_cnt, 1);
    rst_n = 1'b0;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_ctrl", out_ctrl, 0);
    check("mr_occ", occupancy, 0);
    check("mr_stall", stall_cnt, 0);
    check("mr_ready", in_ready, 0);
    rst_n = 1'b1;
    #1 check("mr_rel_ready_low", in_ready, 0);
    tick();
    check("mr_rel_ready_high", in_ready, 1);

    // SKID=0 build: streaming
    n_ready = 1'b1;
    check("n_empty_ready", n_in_ready, 1);
    for (int i = 1; i <= 8; i++) begin
      ndrive(1'b1, 111'(i));
      tick();
      check("n_stream_data", n_out_data, 128'(i));
      check("n_stream_occ", n_occupancy, 1);
      check("n_stream_ready", n_in_ready, 1);
    end
    ndrive(1'b0, '0);
    tick();
    check("n_drain_valid", n_out_valid, 0);
    check("n_drain_ctrl", n_out_ctrl, 0);

    // SKID=0 build: back-pressure
    n_ready = 1'b0;
    ndrive(1'b1, 111'hA);
    tick();
    check("n_bp_data_a", n_out_data, 111'hA);
    check("n_bp_occ", n_occupancy, 1);
    check("n_bp_ready0", n_in_ready, 0);
    ndrive(1'b1, 111'hB);
    tick();
    check("n_bp_hold_a", n_out_data, 111'hA);
    check("n_bp_occ_max1", n_occupancy, 1);
    check("n_bp_ready0b", n_in_ready, 0);
    n_ready = 1'b1;
    #1 check("n_bp_comb_ready", n_in_ready, 1);
    tick();
    check("n_bp_data_b", n_out_data, 111'hB);
    check("n_bp_ctrl_b", n_out_ctrl, cf(111'hB));
    check("n_bp_occ1", n_occupancy, 1);
    ndrive(1'b0, '0);
    tick();
    check("n_bp_empty", n_out_valid, 0);
    check("n_bp_occ0", n_occupancy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
